// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state encoding and defaults for the two-source round-robin arbiter
package arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT0 = 2'd1,
    S_GRANT1 = 2'd2
  } arb_state_e;

  localparam int ARB_MAX_BURST = 4;

endpackage

// File: rtl/mux2_4.sv
// rtl/mux2_4.sv - 2:1 datapath mux, b selected when sel_i is high
module mux2_4 #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/rr_arb2_4.sv
// rtl/rr_arb2_4.sv - round-robin arbiter sharing one mux between two sources,
// with a beat counter capping bursts while the other source waits.
module rr_arb2_4
  import arb_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = ARB_MAX_BURST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] in0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] in1,
  output logic             gnt1,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sel,
  output logic             busy
);

  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e      state_q;
  logic            sel_q;
  logic            last_q;
  logic [CW-1:0]   cnt_q;

  logic            cur_src;
  logic            own_req;
  logic            oth_req;
  logic            xfer;
  logic            last_beat;
  logic            enter_en;
  logic            enter_src;
  logic            go_idle;
  logic            cnt_clr;
  logic            cnt_inc;

  assign busy      = (state_q != S_IDLE);
  assign cur_src   = (state_q == S_GRANT1);
  assign own_req   = cur_src ? req1 : req0;
  assign oth_req   = cur_src ? req0 : req1;
  assign out_valid = !rst && busy && own_req;
  assign xfer      = out_valid && out_ready;
  assign gnt0      = xfer && (state_q == S_GRANT0);
  assign gnt1      = xfer && (state_q == S_GRANT1);
  assign last_beat = (cnt_q == CW'(MAX_BURST - 1));
  assign sel       = sel_q;

  // Decide the next move; enter_en covers both grant from IDLE and a direct owner swap.
  always_comb begin
    enter_en  = 1'b0;
    enter_src = 1'b0;
    go_idle   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          enter_en  = 1'b1;
          enter_src = (req0 && req1) ? ~last_q : req1;
        end
      end
      S_GRANT0, S_GRANT1: begin
        if (!own_req) begin
          if (oth_req) begin
            enter_en  = 1'b1;
            enter_src = ~cur_src;
          end else begin
            go_idle = 1'b1;
          end
        end else if (xfer) begin
          if (last_beat) begin
            if (oth_req) begin
              enter_en  = 1'b1;
              enter_src = ~cur_src;
            end else begin
              cnt_clr = 1'b1;
            end
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: go_idle = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else if (enter_en) begin
      state_q <= enter_src ? S_GRANT1 : S_GRANT0;
      sel_q   <= enter_src;
      last_q  <= enter_src;
      cnt_q   <= '0;
    end else if (go_idle) begin
      state_q <= S_IDLE;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (cnt_inc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  mux2_4 #(.WIDTH(WIDTH)) u_mux (
    .a_i   (in0),
    .b_i   (in1),
    .sel_i (sel_q),
    .y_o   (out_data)
  );

endmodule
